// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive controller.
// Optional idle-timeout feature is selected with UART_RX_IDLE_TIMEOUT_EN.
package uart_pkg;

    localparam int UART_RX_DEPTH   = 16;
    localparam int UART_RX_TIMEOUT = 17280;

    typedef logic [7:0] uart_byte_t;

    // Line-idle timeout FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TOUT = 2'd2
    } rx_tout_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver/CPU-side signal bundle for uart_rx_ctrl.
// Handshake semantics: i_rx_ready is a one-cycle strobe that always carries a
// byte (no back-pressure toward the receiver; a byte arriving while full is
// dropped and flagged). The read side is show-ahead valid/ready: o_rd_valid
// plus o_rd_data describe the head, and a pop happens on a clock edge where
// both o_rd_valid and i_rd_en are 1; i_rd_en with o_rd_valid low is ignored.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_DEPTH
);
    logic                     i_rx_ready;
    uart_byte_t               i_rx_data;
    logic                     i_rd_en;
    logic                     i_clr_ovf;
    logic                     o_rd_valid;
    uart_byte_t               o_rd_data;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_overflow;
    logic                     o_irq;
    rx_tout_state_e           o_dbg_state;

    modport master (
        output i_rx_ready, i_rx_data, i_rd_en, i_clr_ovf,
        input  o_rd_valid, o_rd_data, o_count, o_overflow, o_irq, o_dbg_state
    );

    modport slave (
        input  i_rx_ready, i_rx_data, i_rd_en, i_clr_ovf,
        output o_rd_valid, o_rd_data, o_count, o_overflow, o_irq, o_dbg_state
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO. Push/pop are pre-qualified by the
// caller; full/empty come from the occupancy count, not pointer equality.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  uart_byte_t             i_wr_data,
    input  logic                   i_pop,
    output uart_byte_t             o_rd_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    uart_byte_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && i_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: buffers received bytes for the CPU, flags overflow and raises
// a level interrupt on fill level and (with UART_RX_IDLE_TIMEOUT_EN defined)
// on line-idle timeout.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH          = UART_RX_DEPTH,
    parameter int IRQ_LEVEL      = 1,
    parameter int TIMEOUT_CYCLES = UART_RX_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_tout_nxt;
    logic          r_ovf;
    logic          r_irq;

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_pop  = bus.i_rd_en && !w_empty;
    assign w_push = bus.i_rx_ready && (!w_full || w_pop);
    assign w_drop = bus.i_rx_ready && w_full && !w_pop;

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (bus.i_rx_data),
        .i_pop     (w_pop),
        .o_rd_data (bus.o_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Occupancy after this edge, so the interrupt lines up with o_count
    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop)      w_count_nxt = w_count + 1'b1;
        else if (!w_push && w_pop) w_count_nxt = w_count - 1'b1;
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst)               r_ovf <= 1'b0;
        else if (w_drop)       r_ovf <= 1'b1;
        else if (bus.i_clr_ovf) r_ovf <= 1'b0;
    end

`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    rx_tout_state_e r_state;
    rx_tout_state_e w_state_nxt;
    logic [TW-1:0]  r_tcnt;
    logic [TW-1:0]  w_tcnt_nxt;
    logic           w_pop_empties;

    assign w_pop_empties = w_pop && !w_push && (w_count == CW'(1));

    // Timeout FSM state and idle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Timeout FSM next state; any bus activity restarts the idle count
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_nxt = WAIT;
                    w_tcnt_nxt  = '0;
                end
            end
            WAIT: begin
                if (w_pop_empties) begin
                    w_state_nxt = IDLE;
                    w_tcnt_nxt  = '0;
                end else if (w_push || w_pop) begin
                    w_tcnt_nxt  = '0;
                end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (!w_empty) w_state_nxt = TOUT;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 1'b1;
                end
            end
            TOUT: begin
                if (w_pop_empties) begin
                    w_state_nxt = IDLE;
                    w_tcnt_nxt  = '0;
                end else if (w_push || w_pop) begin
                    w_state_nxt = WAIT;
                    w_tcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tcnt_nxt  = '0;
            end
        endcase
    end

    // Timeout FSM outputs: interrupt term and debug state
    always_comb begin
        w_tout_nxt      = (w_state_nxt == TOUT);
        bus.o_dbg_state = r_state;
    end
`else
    // No timeout logic in this build: constant term and idle debug state
    always_comb begin
        w_tout_nxt      = 1'b0;
        bus.o_dbg_state = IDLE;
    end
`endif

    // Registered level interrupt computed from next-cycle occupancy/state
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= (w_count_nxt >= CW'(IRQ_LEVEL)) || w_tout_nxt;
    end

    assign bus.o_rd_valid = !w_empty;
    assign bus.o_count    = w_count;
    assign bus.o_overflow = r_ovf;
    assign bus.o_irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl. dut_a uses default
// parameters; dut_b uses IRQ_LEVEL=4, TIMEOUT_CYCLES=100 for the timeout case.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DEPTH(16)) ifa ();
    uart_rx_ctrl_if #(.DEPTH(16)) ifb ();

    uart_rx_ctrl #(.DEPTH(16), .IRQ_LEVEL(1), .TIMEOUT_CYCLES(UART_RX_TIMEOUT)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    uart_rx_ctrl #(.DEPTH(16), .IRQ_LEVEL(4), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic rx, input logic [7:0] d, input logic rd, input logic clr);
        @(negedge clk);
        ifa.i_rx_ready = rx;
        ifa.i_rx_data  = d;
        ifa.i_rd_en    = rd;
        ifa.i_clr_ovf  = clr;
        @(posedge clk);
        #1;
        ifa.i_rx_ready = 1'b0;
        ifa.i_rd_en    = 1'b0;
        ifa.i_clr_ovf  = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d);
        if (exp_q.size() < 16) exp_q.push_back(d);
        else                   exp_ovf = 1'b1;
        drive_a(1'b1, d, 1'b0, 1'b0);
    endtask

    // Scoreboard pop: compare head against the expected queue, then pop it
    task automatic pop_a(input string name);
        logic [7:0] e;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: DUT valid=%0b but scoreboard queue empty", name, ifa.o_rd_valid);
        end else begin
            e = exp_q.pop_front();
            if (ifa.o_rd_valid !== 1'b1 || ifa.o_rd_data !== e) begin
                n_fail++;
                $display("FAIL %s: got valid=%0b data=%02h exp valid=1 data=%02h",
                         name, ifa.o_rd_valid, ifa.o_rd_data, e);
            end
        end
        ifa.i_rd_en = 1'b1;
        @(posedge clk);
        #1;
        ifa.i_rd_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        ifa.i_rx_ready = 0; ifa.i_rx_data = 0; ifa.i_rd_en = 0; ifa.i_clr_ovf = 0;
        ifb.i_rx_ready = 0; ifb.i_rx_data = 0; ifb.i_rd_en = 0; ifb.i_clr_ovf = 0;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", ifa.o_count); end
        n_checks++; if (ifa.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", ifa.o_rd_valid); end
        n_checks++; if (ifa.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b exp 0", ifa.o_overflow); end
        n_checks++; if (ifa.o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b exp 0", ifa.o_irq); end
        n_checks++; if (ifa.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h exp 00", ifa.o_rd_data); end
        n_checks++; if (ifa.o_dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", ifa.o_dbg_state, IDLE); end
        n_checks++; if (ifb.o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_b: got %0b exp 0", ifb.o_irq); end
    endtask

    task automatic test_basic_order();
        push_a(8'h41);
        push_a(8'h42);
        push_a(8'h43);
        n_checks++; if (ifa.o_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d exp 3", ifa.o_count); end
        n_checks++; if (ifa.o_irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %0b exp 1", ifa.o_irq); end
        repeat (3) pop_a("basic_pop");
        n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL basic_count_end: got %0d exp 0", ifa.o_count); end
        n_checks++; if (ifa.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end: got %0b exp 0", ifa.o_rd_valid); end
        n_checks++; if (ifa.o_irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_end: got %0b exp 0", ifa.o_irq); end
    endtask

    task automatic test_overflow_full();
        logic [7:0] e;
        for (int i = 0; i <= 16; i++) push_a(8'(i));
        n_checks++; if (ifa.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d exp 16", ifa.o_count); end
        n_checks++; if (ifa.o_overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b exp %0b", ifa.o_overflow, exp_ovf); end
        drive_a(1'b0, 8'h00, 1'b0, 1'b1);
        exp_ovf = 1'b0;
        n_checks++; if (ifa.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b exp 0", ifa.o_overflow); end
        n_checks++; if (ifa.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_clear_count: got %0d exp 16", ifa.o_count); end
        // full FIFO: push 0xAA and pop in the same cycle
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (ifa.o_rd_data !== e) begin n_fail++; $display("FAIL full_pp_head: got %02h exp %02h", ifa.o_rd_data, e); end
        exp_q.push_back(8'hAA);
        ifa.i_rx_ready = 1'b1; ifa.i_rx_data = 8'hAA; ifa.i_rd_en = 1'b1;
        @(posedge clk);
        #1;
        ifa.i_rx_ready = 1'b0; ifa.i_rd_en = 1'b0;
        n_checks++; if (ifa.o_count !== 5'd16) begin n_fail++; $display("FAIL full_pp_count: got %0d exp 16", ifa.o_count); end
        n_checks++; if (ifa.o_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf: got %0b exp 0", ifa.o_overflow); end
        // dropped byte and clear in the same cycle: set wins
        exp_ovf = 1'b1;
        drive_a(1'b1, 8'hEE, 1'b0, 1'b1);
        n_checks++; if (ifa.o_overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set_wins: got %0b exp %0b", ifa.o_overflow, exp_ovf); end
        drive_a(1'b0, 8'h00, 1'b0, 1'b1);
        exp_ovf = 1'b0;
        repeat (16) pop_a("ovf_drain");
        n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL ovf_drain_count: got %0d exp 0", ifa.o_count); end
        n_checks++; if (ifa.o_overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_drain_flag: got %0b exp %0b", ifa.o_overflow, exp_ovf); end
    endtask

    task automatic test_empty_ops();
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (ifa.o_count !== 5'd0 || ifa.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got count=%0d valid=%0b exp 0/0", ifa.o_count, ifa.o_rd_valid); end
        exp_q.push_back(8'h66);
        drive_a(1'b1, 8'h66, 1'b1, 1'b0);
        n_checks++; if (ifa.o_count !== 5'd1) begin n_fail++; $display("FAIL empty_push_pop: got count=%0d exp 1", ifa.o_count); end
        pop_a("empty_push_pop_data");
    endtask

    task automatic test_pointer_wrap();
        for (int i = 0; i < 40; i++) begin
            push_a(8'($urandom_range(0, 255)));
            n_checks++; if (ifa.o_count !== 5'd1) begin n_fail++; $display("FAIL wrap_count_push: got %0d exp 1", ifa.o_count); end
            pop_a("wrap_data");
            n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL wrap_count_pop: got %0d exp 0", ifa.o_count); end
        end
        n_checks++; if (ifa.o_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %0b exp 0", ifa.o_overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) push_a(8'($urandom_range(0, 255)));
        n_checks++; if (ifa.o_count !== 5'd12) begin n_fail++; $display("FAIL b2b_count: got %0d exp 12", ifa.o_count); end
        for (int i = 0; i < 12; i++) pop_a("b2b_data");
        n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d exp 0", ifa.o_count); end
    endtask

    task automatic test_timeout();
        int first_rise;
        int exp_rise;
`ifdef UART_RX_IDLE_TIMEOUT_EN
        exp_rise = 100;
`else
        exp_rise = 0;
`endif
        @(negedge clk);
        ifb.i_rx_ready = 1'b1; ifb.i_rx_data = 8'h5A;
        @(posedge clk);
        #1;
        ifb.i_rx_ready = 1'b0;
        first_rise = 0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk);
            #1;
            if (first_rise == 0 && ifb.o_irq === 1'b1) first_rise = k;
        end
        n_checks++; if (first_rise != exp_rise) begin n_fail++; $display("FAIL tout_rise: irq rose after %0d clocks exp %0d (0 = never)", first_rise, exp_rise); end
        @(negedge clk);
        n_checks++; if (ifb.o_rd_data !== 8'h5A) begin n_fail++; $display("FAIL tout_data: got %02h exp 5a", ifb.o_rd_data); end
        ifb.i_rd_en = 1'b1;
        @(posedge clk);
        #1;
        ifb.i_rd_en = 1'b0;
        n_checks++; if (ifb.o_irq !== 1'b0 || ifb.o_count !== 5'd0) begin n_fail++; $display("FAIL tout_pop: got irq=%0b count=%0d exp 0/0", ifb.o_irq, ifb.o_count); end
        n_checks++; if (ifb.o_dbg_state !== IDLE) begin n_fail++; $display("FAIL tout_state: got %0d exp %0d", ifb.o_dbg_state, IDLE); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_a(8'(8'h10 + i));
        @(negedge clk);
        rst = 1'b1;
        ifa.i_rx_ready = 1'b1; ifa.i_rx_data = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.i_rx_ready = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        n_checks++; if (ifa.o_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d exp 0", ifa.o_count); end
        n_checks++; if (ifa.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b exp 0", ifa.o_rd_valid); end
        n_checks++; if (ifa.o_irq !== 1'b0 || ifa.o_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got irq=%0b ovf=%0b exp 0/0", ifa.o_irq, ifa.o_overflow); end
        n_checks++; if (ifa.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %02h exp 00", ifa.o_rd_data); end
        push_a(8'h55);
        n_checks++; if (ifa.o_count !== 5'd1) begin n_fail++; $display("FAIL rstmid_push_count: got %0d exp 1", ifa.o_count); end
        pop_a("rstmid_readback");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_order();
        test_overflow_full();
        test_empty_ops();
        test_pointer_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries left exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART: it captures each completed byte from the UART receiver, buffers it in a small FIFO, and presents it to the CPU bus as a show-ahead read stream. It tracks buffer occupancy and flags overflow. It generates a level interrupt on a fill threshold and, when configured, on line-idle timeout. It sits between the UART receiver and the SoC peripheral register block.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `IRQ_LEVEL`, 1: occupancy at or above which `o_irq` asserts. Range 1..DEPTH.
- `TIMEOUT_CYCLES`, 17280: idle clocks before timeout (4 characters at 115200 bps / 50 MHz). Must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_ready`  in  1  one-cycle pulse: receiver byte complete.
- `i_rx_data`  in  8  received byte, valid while `i_rx_ready` is high.
- `i_rd_en`  in  1  pop request; honoured only while `o_rd_valid` = 1.
- `o_rd_valid`  out  1  FIFO not empty.
- `o_rd_data`  out  8  head byte (show-ahead). Value is don't-care while empty.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_overflow`  out  1  sticky: a byte was dropped.
- `i_clr_ovf`  in  1  clears `o_overflow`.
- `o_irq`  out  1  level interrupt.

## Operation
- **Push:** on `i_rx_ready` = 1 with FIFO not full, `i_rx_data` is written at the tail.
  - If the FIFO is full, the byte is discarded and `o_overflow` is set.
- **Pop:** on `i_rd_en` = 1 with `o_rd_valid` = 1, the head advances.
  - `i_rd_en` while empty is ignored and has no side effects.
- **Simultaneous push + pop:**
  - Full FIFO: both are performed. Count is unchanged and no overflow occurs.
  - Empty FIFO: the pop is ignored, the push occurs, and count becomes 1.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `o_count`, never from pointer equality alone.
- **Overflow flag:**
  - Set and clear in the same cycle: set wins.
  - `i_clr_ovf` does not affect FIFO contents.
- **Interrupt:** `o_irq` = (`o_count` ≥ IRQ_LEVEL) OR timeout flag. The timeout term exists only when configured.
- **Timeout FSM** (only when configured):
  - States: IDLE, WAIT, TOUT.
  - IDLE → WAIT on a push.
  - WAIT: counter increments each clock; any push or pop clears it to 0.
  - WAIT → TOUT when the counter reaches TIMEOUT_CYCLES-1 while the FIFO is non-empty.
  - TOUT → WAIT on a push.
  - WAIT or TOUT → IDLE when a pop leaves the FIFO empty; a pop that leaves the FIFO non-empty moves TOUT → WAIT.
  - Timeout flag = (state == TOUT).

## Timing
- **Reset:** `o_rd_valid`=0, `o_count`=0, `o_overflow`=0, `o_irq`=0, `o_rd_data`=0. Pointers are 0 and the FSM is in IDLE.
- **Reset mid-operation:** discards all buffered bytes. A push coinciding with `rst` is lost.
- **Push latency:** push at edge N gives `o_rd_valid`, `o_count` and `o_rd_data` valid after edge N+1 (one cycle).
- **Pop latency:** pop at edge N gives the next head byte and the decremented count after edge N+1.
- **Register/output timing:** `o_irq`, `o_overflow` and `o_count` are registered. `o_rd_valid` and `o_rd_data` are decoded from registered state only, with no combinational path from any input.
- **Back-to-back:** pushes at the UART rate and pops every cycle are both sustained with no bubbles.

## Configuration
- **`UART_RX_IDLE_TIMEOUT_EN` defined:** the timeout counter and FSM are compiled in, and `o_irq` includes the timeout term.
- **Undefined:** no counter or FSM is present, `o_irq` = (`o_count` ≥ IRQ_LEVEL) only, and `TIMEOUT_CYCLES` is unused.
- **Unaffected:** ports and parameters are identical in both builds.

## Structure
- **Package `uart_pkg`:**
  - Timeout FSM state enum (IDLE, WAIT, TOUT).
  - Default constants: UART_RX_DEPTH=16, UART_RX_TIMEOUT=17280.
  - Byte typedef `uart_byte_t` (logic [7:0]).
- **Sub-module `uart_rx_fifo`:** storage array, pointers, count, full/empty.
  - Push/pop inputs, show-ahead output.
- **`uart_rx_ctrl`:** instantiates `uart_rx_fifo` and owns the overflow, IRQ and timeout logic.

## Test plan
- **Reset and basic order:** push 0x41, 0x42, 0x43, then pop three times.
  - After the pushes: `o_count`=3, `o_irq`=1.
  - Popped data 0x41, 0x42, 0x43 in order.
  - After the last pop: `o_count`=0, `o_rd_valid`=0, `o_irq`=0.
- **Overflow:** with DEPTH=16, push 17 bytes 0x00..0x10 with no pops.
  - `o_count`=16 and `o_overflow`=1.
  - Popping all gives 0x00..0x0F; 0x10 is lost.
  - `i_clr_ovf` then drops `o_overflow` to 0.
- **Full push+pop:** with the FIFO full, pulse `i_rx_ready` (0xAA) and `i_rd_en` in the same cycle.
  - `o_count` stays 16 and `o_overflow` stays 0.
  - 0xAA is the last byte read out.
- **Pointer wrap:** push and pop 40 bytes one at a time.
  - Data matches, `o_count` ≤ 1 throughout, no overflow.
- **Timeout (macro on):** IRQ_LEVEL=4, TIMEOUT_CYCLES=100; push one byte and wait.
  - `o_irq` rises exactly 100 clocks after the push.
  - A pop clears it in the next cycle.
  - With the macro off, `o_irq` stays 0.
- **Reset mid-stream:** push 5 bytes and assert `rst` for one cycle.
  - All outputs return to their reset values.
  - A subsequent push of 0x55 reads back as 0x55.
